// File: rtl/alu_cmd_pkg.sv
// Shared encodings and widths for the ALU command engine.
package alu_cmd_pkg;
  localparam int OPND_W = 8;
  localparam int RES_W  = 12;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;
endpackage

// File: rtl/alu_cmd_if.sv
// Command/response handshake bundle for the ALU command engine.
// master = command source and response sink; slave = the engine.
interface alu_cmd_if #(parameter int TAG_W = 4);
  import alu_cmd_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [OPND_W-1:0] cmd_a;
  logic [OPND_W-1:0] cmd_b;
  logic              cmd_cin;
  logic [TAG_W-1:0]  cmd_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_carry;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag
  );
endinterface

// File: rtl/alu_cmd_alu.sv
// Combinational ALU: 4-bit ADD with carry, 8-bit SUB with borrow, 6x6 MUL, 4-bit AND.
module alu_cmd_alu
  import alu_cmd_pkg::*;
(
  input  op_e               i_op,
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  input  logic              i_cin,
  output logic [RES_W-1:0]  o_result,
  output logic              o_carry
);
  logic [4:0]       w_sum;
  logic [8:0]       w_diff;
  logic [RES_W-1:0] w_prod;

  assign w_sum  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
  // Ninth bit of the widened difference is the borrow (set iff a < b).
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod = {6'b0, i_a[5:0]} * {6'b0, i_b[5:0]};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = {8'b0, w_sum[3:0]};
        o_carry  = w_sum[4];
      end
      OP_SUB: begin
        o_result = {4'b0, w_diff[7:0]};
        o_carry  = w_diff[8];
      end
      OP_MUL:  o_result = w_prod;
      OP_AND:  o_result = {8'b0, i_a[3:0] & i_b[3:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_cmd_engine.sv
// One-at-a-time ALU command engine: IDLE -> EXEC -> RESP, response 2 edges after accept.
// Optional completed-response counter enabled by the ALU_CMD_STATS_EN macro.
module alu_cmd_engine
  import alu_cmd_pkg::*;
#(
  parameter int TAG_W = 4
`ifdef ALU_CMD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  alu_cmd_if.slave        bus,
  output logic            busy
`ifdef ALU_CMD_STATS_EN
  , output logic [CNT_W-1:0] op_count
`endif
);
  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic              w_rsp_done;

  op_e               r_op;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  logic              r_cin;
  logic [TAG_W-1:0]  r_tag;

  logic [RES_W-1:0]  w_alu_result;
  logic              w_alu_carry;
  logic [RES_W-1:0]  r_rsp_result;
  logic              r_rsp_carry;
  logic [TAG_W-1:0]  r_rsp_tag;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= OP_ADD;
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_op  <= bus.cmd_op;
      r_a   <= bus.cmd_a;
      r_b   <= bus.cmd_b;
      r_cin <= bus.cmd_cin;
      r_tag <= bus.cmd_tag;
    end
  end

  alu_cmd_alu u_alu (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_cin    (r_cin),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry)
  );

  // Response fields load only in EXEC, so they stay frozen through RESP backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_result <= w_alu_result;
      r_rsp_carry  <= w_alu_carry;
      r_rsp_tag    <= r_tag;
    end
  end

  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.rsp_tag    = r_rsp_tag;
  assign busy           = (r_state != ST_IDLE);

`ifdef ALU_CMD_STATS_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)                             r_count <= '0;
    else if (w_rsp_done && r_count != '1) r_count <= r_count + CNT_W'(1);
  end

  assign op_count = r_count;
`else
  logic w_unused_done;
  assign w_unused_done = w_rsp_done;
`endif
endmodule
